// File: rtl/dff_q_qbar_pkg.sv
// Shared constants and types for the dff_q_qbar storage cell.
// Message tags are used by the optional DFF_Q_QBAR_ASSERT_EN checks.
package dff_q_qbar_pkg;

   localparam int   DEFAULT_WIDTH     = 1;
   localparam logic DEFAULT_RESET_BIT = 1'b0;

   typedef logic [DEFAULT_WIDTH-1:0] lane_t;

   localparam string MSG_RST   = "dff_q_qbar: output not at reset value while rstn low";
   localparam string MSG_XD    = "dff_q_qbar: X/Z on d at load edge";
   localparam string MSG_QQBAR = "dff_q_qbar: ybar is not the complement of y";
   localparam string MSG_LOAD  = "dff_q_qbar: y does not match d sampled at previous load";

endpackage

// File: rtl/dff_q_qbar_cell.sv
// Single-bit D flip-flop with registered Q and Q-bar and an asynchronous
// active-low clear to a per-cell reset value.
module dff_q_qbar_cell
   import dff_q_qbar_pkg::*;
#(
   parameter logic RESET_VALUE = DEFAULT_RESET_BIT
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic y,
   output logic ybar
);

   logic y_q;
   logic ybar_q;
   logic y_d;
   logic ybar_d;

   assign y_d    = d;
   assign ybar_d = ~d;

   // Q-bar has its own flop so both outputs switch from the same edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         y_q    <= RESET_VALUE;
         ybar_q <= ~RESET_VALUE;
      end else begin
         y_q    <= y_d;
         ybar_q <= ybar_d;
      end
   end

   assign y    = y_q;
   assign ybar = ybar_q;

endmodule

// File: rtl/dff_q_qbar.sv
// WIDTH-lane D flip-flop with complementary outputs and async active-low clear.
// Define DFF_Q_QBAR_ASSERT_EN to compile the built-in immediate assertions.
module dff_q_qbar
   import dff_q_qbar_pkg::*;
#(
   parameter int               WIDTH       = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{DEFAULT_RESET_BIT}}
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] ybar
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      dff_q_qbar_cell #(
         .RESET_VALUE (RESET_VALUE[i])
      ) u_cell (
         .clk  (clk),
         .rstn (rstn),
         .d    (d[i]),
         .y    (y[i]),
         .ybar (ybar[i])
      );
   end

`ifdef DFF_Q_QBAR_ASSERT_EN
   logic             loaded_q;
   logic [WIDTH-1:0] d_prev_q;

   // loaded_q marks that the previous edge stored d; any reset in between clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         loaded_q <= 1'b0;
      end else begin
         loaded_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      d_prev_q <= d;
   end

   always @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (!rstn) begin
            assert (y[i] === RESET_VALUE[i] && ybar[i] === ~RESET_VALUE[i])
               else $error("%s lane %0d y=%b ybar=%b reset=%b", MSG_RST, i, y[i], ybar[i], RESET_VALUE[i]);
         end else begin
            assert (!$isunknown(d[i]))
               else $error("%s lane %0d d=%b", MSG_XD, i, d[i]);
            if (loaded_q) begin
               assert (y[i] === d_prev_q[i])
                  else $error("%s lane %0d y=%b d_prev=%b", MSG_LOAD, i, y[i], d_prev_q[i]);
            end
         end
         assert (ybar[i] === ~y[i])
            else $error("%s lane %0d y=%b ybar=%b", MSG_QQBAR, i, y[i], ybar[i]);
      end
   end
`endif

endmodule

// File: tb/tb_dff_q_qbar.sv
// Directed and short random bench for dff_q_qbar with a scoreboard of expected outputs.
// Two instances share stimulus: one with an all-zero reset value, one with a mixed pattern.
module tb_dff_q_qbar;

   localparam int         W   = 4;
   localparam logic [W-1:0] RV0 = 4'b0000;
   localparam logic [W-1:0] RV1 = 4'b1010;

   logic         clk;
   logic         rstn;
   logic [W-1:0] d;
   logic [W-1:0] y0, ybar0;
   logic [W-1:0] y1, ybar1;

   typedef struct {
      logic [W-1:0] y0;
      logic [W-1:0] y1;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   dff_q_qbar #(.WIDTH(W), .RESET_VALUE(RV0)) u_dut0 (
      .clk  (clk),
      .rstn (rstn),
      .d    (d),
      .y    (y0),
      .ybar (ybar0)
   );

   dff_q_qbar #(.WIDTH(W), .RESET_VALUE(RV1)) u_dut1 (
      .clk  (clk),
      .rstn (rstn),
      .d    (d),
      .y    (y1),
      .ybar (ybar1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs: reset value while in reset, otherwise the loaded data.
   task automatic push_exp(input logic in_reset, input logic [W-1:0] dval);
      exp_t e;
      e.y0 = in_reset ? RV0 : dval;
      e.y1 = in_reset ? RV1 : dval;
      sb.push_back(e);
   endtask

   task automatic check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: scoreboard empty, observed y0=%b", tag, y0);
         return;
      end
      e = sb.pop_front();
      tests++;
      assert (y0 === e.y0) else begin
         fails++;
         $error("FAIL %s y0: observed %b expected %b", tag, y0, e.y0);
      end
      tests++;
      assert (ybar0 === ~e.y0) else begin
         fails++;
         $error("FAIL %s ybar0: observed %b expected %b", tag, ybar0, ~e.y0);
      end
      tests++;
      assert (y1 === e.y1) else begin
         fails++;
         $error("FAIL %s y1: observed %b expected %b", tag, y1, e.y1);
      end
      tests++;
      assert (ybar1 === ~e.y1) else begin
         fails++;
         $error("FAIL %s ybar1: observed %b expected %b", tag, ybar1, ~e.y1);
      end
   endtask

   initial begin
      logic [W-1:0] rd;
      logic         rr;

      // Power-up reset with d high; a real falling edge on rstn triggers the clear.
      rstn = 1'b1;
      d    = '1;
      #1 rstn = 1'b0;
      #1 push_exp(1'b1, d);
      check("rst_init");
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1 push_exp(1'b1, d);
         check("rst_hold");
      end

      // Release mid-cycle, then load ones and zeros.
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1 push_exp(1'b0, 4'b1111);
      check("load1");
      @(negedge clk);
      d = '0;
      @(posedge clk);
      #1 push_exp(1'b0, 4'b0000);
      check("load0");

      // Glitch on d between edges leaves outputs untouched.
      @(negedge clk);
      #1 d = '1;
      #1 push_exp(1'b0, 4'b0000);
      check("glitch_hi");
      #1 d = '0;
      #1 push_exp(1'b0, 4'b0000);
      check("glitch_lo");
      @(posedge clk);
      #1 push_exp(1'b0, 4'b0000);
      check("glitch_edge");

      // Load a pattern, then clear asynchronously mid-cycle.
      @(negedge clk);
      d = 4'b0110;
      @(posedge clk);
      #1 push_exp(1'b0, 4'b0110);
      check("pre_clr");
      d = '1;
      #2 rstn = 1'b0;
      #1 push_exp(1'b1, d);
      check("async_clr");
      @(posedge clk);
      #1 push_exp(1'b1, d);
      check("clr_hold_edge");

      // Release exactly at a rising edge: that edge must not load.
      @(posedge clk);
      rstn <= 1'b1;
      #1 push_exp(1'b1, d);
      check("rel_edge");
      @(posedge clk);
      #1 push_exp(1'b0, 4'b1111);
      check("rel_next");

      // Random d and rstn, changed away from the rising edge.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         rd   = W'($urandom);
         rr   = (k == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
         d    = rd;
         rstn = rr;
         @(posedge clk);
         #1 push_exp(!rr, rd);
         check("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dff_q_qbar.md
Name: dff_q_qbar

Overview:
- Positive-edge D flip-flop with complementary outputs y (Q) and ybar (Q-bar).
- Asynchronous active-low clear.
- Leaf storage cell for control and datapath registers.
- Also serves as the reference target for the immediate-assertion checks.

Parameters:
- WIDTH, 1, number of independent D/Q bit lanes; all lanes share clk and rstn.
- RESET_VALUE, '0 (WIDTH bits), value loaded into y during reset; ybar resets to ~RESET_VALUE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- d  input  WIDTH  data sampled on the rising edge of clk.
- y  output  WIDTH  registered data (Q).
- ybar  output  WIDTH  bitwise complement of y (Q-bar).

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, named rstn. The polarity and synchronicity of reset are fixed.
- Reset:
  - rstn low immediately forces y=RESET_VALUE and ybar=~RESET_VALUE, with no clock needed.
  - Outputs hold these values while rstn stays low, whatever d and clk do.
- Normal operation:
  - On a posedge clk with rstn high: y<=d and ybar<=~d.
  - Latency is exactly 1 clock edge; no enable and no handshake.
- Hold: between rising edges, y and ybar do not change; falling edges and d glitches have no effect.
- Invariant: ybar == ~y at all times, bit for bit. ybar is registered alongside y (not combinationally inverted) so both outputs change from the same edge.
- Reset asserted mid-operation:
  - Outputs clear asynchronously at the rstn falling edge.
  - The previously stored value is lost.
- Reset release coincident with posedge clk: that edge does not load d; the first load is on the next rising edge with rstn high.
- X/Z on d: propagates into y, and its complement into ybar, in simulation; no masking.
- Lanes are independent; no cross-lane logic.

Optional Feature:
- Macro: DFF_Q_QBAR_ASSERT_EN.
- Defined: the block compiles immediate assertions in its clocked process, each failing via $error with lane index and values.
  - (a) While rstn is low: y==RESET_VALUE and ybar==~RESET_VALUE.
  - (b) At every posedge clk with rstn high: no X/Z on d (checked with $isunknown).
  - (c) At every posedge clk: ybar === ~y.
  - (d) One edge after a load: y equals the d value sampled at that load.
- Undefined: no assertion code, no $error calls; functional behaviour identical.

Decomposition:
- Package dff_q_qbar_pkg:
  - default WIDTH constant;
  - default RESET_VALUE constant;
  - typedef for the lane vector (logic [WIDTH-1:0]);
  - assertion message-format constants.
- One natural sub-module, dff_q_qbar_cell: a single-bit flop with its own y/ybar pair and reset value, instantiated WIDTH times via generate.
- The top level holds the generate loop and the optional assertion block.

Test Plan:
- Power-up reset: rstn=0 and d=1 for 2 cycles -> y=0, ybar=1 throughout, including during clk edges.
- Load: rstn=1; d=1 before posedge -> after the edge y=1, ybar=0; then d=0 -> next edge y=0, ybar=1.
- Mid-cycle d glitch: d toggles 0->1->0 between edges with y=0 -> y stays 0 and ybar stays 1 until the next edge.
- Async reset mid-operation: y=1, then rstn falls mid-cycle -> y=0 and ybar=1 immediately, before the next clk edge.
- Reset release on a clock edge: rstn rises at the same time as posedge with d=1 -> y stays 0; next edge gives y=1.
- Random: 5 cycles of random d/rstn -> every edge ybar==~y; y equals the previous d when rstn=1, else 0. With DFF_Q_QBAR_ASSERT_EN defined, no $error occurs.
